brch_resolve_unit: RTL and testbench

Branch resolution and misprediction recovery unit: the consumer of the 2-bit dynamic predictor's IF-stage prediction and the producer of its training inputs. It records each predicted branch at IF in a small in-order queue and compares the recorded prediction against the outcome resolved in ID. On a mismatch it issues a flush and a redirect PC to fetch. On every resolution it emits a one-cycle train pulse (index, outcome) back to the predictor, and it keeps saturating branch and mispredict counters.

---
 rtl/brch_resolve_unit.sv | 192 +++++++++++++++++++
 tb/tb_brch_resolve_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brch_resolve_unit.sv
// brch_resolve_unit
//
// Branch resolution and misprediction recovery. Every branch predicted in IF
// is recorded, in order, as {pc, pred_taken} in a small circular queue. When
// ID resolves the oldest in-flight branch, its outcome is compared against the
// recorded prediction:
//   - match    : the entry is popped.
//   - mismatch : the whole queue is cleared, flush/redirect are raised for
//                FLUSH_CYC cycles and fetch is pointed at the correct path.
// Every accepted resolve emits a one-cycle train pulse back to the predictor.
// Saturating branch and mispredict counters are kept.
//
// Parameters
//   DEPTH      in-flight queue entries (power of two, 2..8)
//   CNT_W      performance counter width
//   FLUSH_CYC  cycles spent in RECOVER after a mispredict (1..4)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pred_valid_IF/pred_taken_IF/pc_IF   branch prediction to record
//   stall                      blocks both push and resolve
//   res_valid_ID/res_taken_ID/res_target_ID  resolution of the oldest branch
//   train_valid/train_taken/train_idx   predictor update (pc[6:2])
//   flush, redirect_valid, redirect_pc  misprediction recovery
//   q_full, q_empty            queue status
//   br_count, mispred_count    saturating performance counters
//   proto_err                  sticky protocol error

module brch_resolve_unit #(
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid_IF,
    input  logic             pred_taken_IF,
    input  logic [31:0]      pc_IF,
    input  logic             stall,
    input  logic             res_valid_ID,
    input  logic             res_taken_ID,
    input  logic [31:0]      res_target_ID,
    output logic             train_valid,
    output logic             train_taken,
    output logic [4:0]       train_idx,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             q_full,
    output logic             q_empty,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             proto_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [1:0] RCV_LOAD = 2'(FLUSH_CYC - 1);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [1:0] rcv_cnt;

    logic [31:0]      q_pc   [DEPTH];
    logic             q_pred [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0]    wr_idx, rd_idx;

    logic        in_run;
    logic        push_req, res_req;
    logic        push, pop, mispred, proto_hit;
    logic [31:0] head_pc;
    logic        head_pred;
    logic        recover_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Queue status: equal pointers mean empty; equal low bits with differing
    // wrap bits mean full.
    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    assign head_pc   = q_pc[rd_idx];
    assign head_pred = q_pred[rd_idx];

    assign in_run   = (state == RUN);
    assign push_req = pred_valid_IF & ~stall & in_run;
    assign res_req  = res_valid_ID & ~stall & in_run;
    assign pop      = res_req & ~q_empty;
    // A pop frees the head slot in the same cycle, so a full queue still
    // accepts a push alongside a pop.
    assign push     = push_req & (~q_full | pop);
    assign mispred  = pop & (res_taken_ID != head_pred);
    assign proto_hit = (push_req & q_full & ~pop) | (res_req & q_empty);

    assign flush          = recover_q;
    assign redirect_valid = recover_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (mispred) state_nxt = RECOVER;
            RECOVER: if (rcv_cnt == 2'd0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Recovery counter and the flush/redirect strobe: raised on the
    // mispredict edge, dropped on the edge that leaves RECOVER, giving
    // exactly FLUSH_CYC visible cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcv_cnt   <= 2'd0;
            recover_q <= 1'b0;
        end else if (mispred) begin
            rcv_cnt   <= RCV_LOAD;
            recover_q <= 1'b1;
        end else if (state == RECOVER) begin
            if (rcv_cnt == 2'd0) begin
                recover_q <= 1'b0;
            end else begin
                rcv_cnt <= rcv_cnt - 2'd1;
            end
        end
    end

    // Queue storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_idx]   <= pc_IF;
            q_pred[wr_idx] <= pred_taken_IF;
        end
    end

    // Pointers: a mispredict empties the queue and discards any same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispred) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Predictor training, redirect target, counters and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_valid   <= 1'b0;
            train_taken   <= 1'b0;
            train_idx     <= 5'd0;
            redirect_pc   <= 32'd0;
            br_count      <= '0;
            mispred_count <= '0;
            proto_err     <= 1'b0;
        end else begin
            train_valid <= pop;
            if (pop) begin
                train_taken <= res_taken_ID;
                train_idx   <= head_pc[6:2];
                br_count    <= sat_inc(br_count);
            end
            if (mispred) begin
                redirect_pc   <= res_taken_ID ? res_target_ID : head_pc + 32'd4;
                mispred_count <= sat_inc(mispred_count);
            end
            if (proto_hit) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_brch_resolve_unit.sv
module tb_brch_resolve_unit;

    localparam int DEPTH     = 2;
    localparam int CNT_W     = 4;
    localparam int FLUSH_CYC = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pred_valid_IF, pred_taken_IF, stall;
    logic [31:0]      pc_IF;
    logic             res_valid_ID, res_taken_ID;
    logic [31:0]      res_target_ID;
    logic             train_valid, train_taken, flush, redirect_valid;
    logic [4:0]       train_idx;
    logic [31:0]      redirect_pc;
    logic             q_full, q_empty, proto_err;
    logic [CNT_W-1:0] br_count, mispred_count;

    int checks   = 0;
    int failures = 0;

    brch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid_IF(pred_valid_IF), .pred_taken_IF(pred_taken_IF), .pc_IF(pc_IF),
        .stall(stall),
        .res_valid_ID(res_valid_ID), .res_taken_ID(res_taken_ID), .res_target_ID(res_target_ID),
        .train_valid(train_valid), .train_taken(train_taken), .train_idx(train_idx),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .q_full(q_full), .q_empty(q_empty),
        .br_count(br_count), .mispred_count(mispred_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             tv;
        logic             tt;
        logic [4:0]       ti;
        logic             fl;
        logic             rv;
        logic [31:0]      rpc;
        logic             qf;
        logic             qe;
        logic [CNT_W-1:0] br;
        logic [CNT_W-1:0] mp;
        logic             pe;
    } exp_t;

    typedef struct packed {
        logic        pv;
        logic        pt;
        logic [31:0] pc;
        logic        st;
        logic        rv;
        logic        rt;
        logic [31:0] tgt;
        logic        etv;
        logic        efl;
        logic        eqe;
        logic        eqf;
        logic [31:0] erpc;
    } vec_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc[$];
    logic        m_pred[$];
    int          m_rec;
    exp_t        m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc.delete();
        m_pred.delete();
        m_rec = 0;
        m_out = '0;
        m_out.qe = 1'b1;
        sb.delete();
    endtask

    task automatic model_step();
        logic        full, empty, pop, push, mis;
        logic [31:0] hpc;
        logic        hpred;
        m_out.tv = 1'b0;
        if (m_rec != 0) begin
            m_rec--;
            if (m_rec == 0) begin
                m_out.fl = 1'b0;
                m_out.rv = 1'b0;
            end
        end else begin
            full  = (m_pc.size() == DEPTH);
            empty = (m_pc.size() == 0);
            pop   = res_valid_ID && !stall && !empty;
            push  = pred_valid_IF && !stall && (!full || pop);
            if ((pred_valid_IF && !stall && full && !pop) || (res_valid_ID && !stall && empty))
                m_out.pe = 1'b1;
            mis = 1'b0;
            if (pop) begin
                hpc   = m_pc[0];
                hpred = m_pred[0];
                m_out.tv = 1'b1;
                m_out.tt = res_taken_ID;
                m_out.ti = hpc[6:2];
                if (m_out.br != {CNT_W{1'b1}}) m_out.br = m_out.br + 1'b1;
                mis = (res_taken_ID != hpred);
                if (mis) begin
                    if (m_out.mp != {CNT_W{1'b1}}) m_out.mp = m_out.mp + 1'b1;
                    m_pc.delete();
                    m_pred.delete();
                    m_out.fl  = 1'b1;
                    m_out.rv  = 1'b1;
                    m_out.rpc = res_taken_ID ? res_target_ID : hpc + 32'd4;
                    m_rec = FLUSH_CYC;
                end else begin
                    void'(m_pc.pop_front());
                    void'(m_pred.pop_front());
                end
            end
            if (push && !mis) begin
                m_pc.push_back(pc_IF);
                m_pred.push_back(pred_taken_IF);
            end
        end
        m_out.qe = (m_pc.size() == 0);
        m_out.qf = (m_pc.size() == DEPTH);
        sb.push_back(m_out);
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [31:0] pc, input logic st,
                         input logic rv, input logic rt, input logic [31:0] tgt);
        pred_valid_IF = pv;
        pred_taken_IF = pt;
        pc_IF         = pc;
        stall         = st;
        res_valid_ID  = rv;
        res_taken_ID  = rt;
        res_target_ID = tgt;
    endtask

    // Apply current inputs for one clock and compare against the scoreboard.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("train_valid", {31'd0, train_valid}, {31'd0, e.tv});
            if (e.tv) begin
                chk("train_taken", {31'd0, train_taken}, {31'd0, e.tt});
                chk("train_idx", {27'd0, train_idx}, {27'd0, e.ti});
            end
            chk("flush", {31'd0, flush}, {31'd0, e.fl});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
            chk("redirect_pc", redirect_pc, e.rpc);
            chk("q_full", {31'd0, q_full}, {31'd0, e.qf});
            chk("q_empty", {31'd0, q_empty}, {31'd0, e.qe});
            chk("br_count", 32'(br_count), 32'(e.br));
            chk("mispred_count", 32'(mispred_count), 32'(e.mp));
            chk("proto_err", {31'd0, proto_err}, {31'd0, e.pe});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_train_valid"}, {31'd0, train_valid}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
        chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, "_q_full"}, {31'd0, q_full}, 32'd0);
        chk({tag, "_q_empty"}, {31'd0, q_empty}, 32'd1);
        chk({tag, "_br_count"}, 32'(br_count), 32'd0);
        chk({tag, "_mispred_count"}, 32'(mispred_count), 32'd0);
        chk({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 32'd0, 0, 0, 0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input logic pv, input logic pt, input logic [31:0] pc,
                                input logic st, input logic rv, input logic rt,
                                input logic [31:0] tgt, input logic etv, input logic efl,
                                input logic eqe, input logic eqf, input logic [31:0] erpc);
        vec_t v;
        v.pv = pv; v.pt = pt; v.pc = pc; v.st = st; v.rv = rv; v.rt = rt; v.tgt = tgt;
        v.etv = etv; v.efl = efl; v.eqe = eqe; v.eqf = eqf; v.erpc = erpc;
        return v;
    endfunction

    vec_t vt[25];

    initial begin
        //            pv pt pc            st rv rt tgt           tv fl qe qf rpc
        vt[0]  = mk(1, 0, 32'h100,      0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0);
        vt[1]  = mk(0, 0, 32'h0,        0, 1, 0, 32'h0,      1, 0, 1, 0, 32'h0);
        vt[2]  = mk(1, 0, 32'h104,      0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0);
        vt[3]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h200,    1, 1, 1, 0, 32'h200);
        vt[4]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 1, 1, 0, 32'h200);
        vt[5]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 1, 1, 0, 32'h200);
        vt[6]  = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h200);
        vt[7]  = mk(1, 1, 32'h20,       0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h200);
        vt[8]  = mk(1, 1, 32'h40,       0, 1, 0, 32'h0,      1, 1, 1, 0, 32'h24);
        vt[9]  = mk(1, 0, 32'h60,       0, 0, 0, 32'h0,      0, 1, 1, 0, 32'h24);
        vt[10] = mk(0, 0, 32'h0,        0, 1, 1, 32'h400,    0, 1, 1, 0, 32'h24);
        vt[11] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h24);
        vt[12] = mk(1, 1, 32'h300,      0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h24);
        vt[13] = mk(1, 0, 32'h304,      0, 0, 0, 32'h0,      0, 0, 0, 1, 32'h24);
        vt[14] = mk(1, 1, 32'h308,      0, 1, 1, 32'h500,    1, 0, 0, 1, 32'h24);
        vt[15] = mk(1, 0, 32'h30C,      0, 0, 0, 32'h0,      0, 0, 0, 1, 32'h24);
        vt[16] = mk(0, 0, 32'h0,        1, 1, 0, 32'h0,      0, 0, 0, 1, 32'h24);
        vt[17] = mk(0, 0, 32'h0,        0, 1, 0, 32'h0,      1, 0, 0, 0, 32'h24);
        vt[18] = mk(0, 0, 32'h0,        0, 1, 1, 32'h600,    1, 0, 1, 0, 32'h24);
        vt[19] = mk(0, 0, 32'h0,        0, 1, 0, 32'h0,      0, 0, 1, 0, 32'h24);
        vt[20] = mk(1, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h24);
        vt[21] = mk(0, 0, 32'h0,        0, 1, 0, 32'h55,     1, 1, 1, 0, 32'h0);
        vt[22] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 1, 1, 0, 32'h0);
        vt[23] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 1, 1, 0, 32'h0);
        vt[24] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h0);

        rst_n = 1'b0;
        drive(0, 0, 32'd0, 0, 0, 0, 32'd0);
        #12;
        check_reset_vals("init");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Directed table
        for (int i = 0; i < 25; i++) begin
            drive(vt[i].pv, vt[i].pt, vt[i].pc, vt[i].st, vt[i].rv, vt[i].rt, vt[i].tgt);
            cycle();
            chk($sformatf("tbl%0d_train_valid", i), {31'd0, train_valid}, {31'd0, vt[i].etv});
            chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, {31'd0, vt[i].efl});
            chk($sformatf("tbl%0d_q_empty", i), {31'd0, q_empty}, {31'd0, vt[i].eqe});
            chk($sformatf("tbl%0d_q_full", i), {31'd0, q_full}, {31'd0, vt[i].eqf});
            chk($sformatf("tbl%0d_redirect_pc", i), redirect_pc, vt[i].erpc);
        end
        chk("tbl_br_count", 32'(br_count), 32'd7);
        chk("tbl_mispred_count", 32'(mispred_count), 32'd3);
        chk("tbl_proto_err", {31'd0, proto_err}, 32'd1);

        // Resolve on an empty queue raises the sticky error
        do_reset();
        drive(0, 0, 32'd0, 0, 1, 1, 32'h80);
        cycle();
        chk("empty_res_train", {31'd0, train_valid}, 32'd0);
        chk("empty_res_proto", {31'd0, proto_err}, 32'd1);
        drive(0, 0, 32'd0, 0, 0, 0, 32'd0);
        cycle();
        cycle();
        chk("proto_sticky", {31'd0, proto_err}, 32'd1);

        // br_count saturation
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 32'(i * 4), 0, 0, 0, 32'd0);
            cycle();
            drive(0, 0, 32'd0, 0, 1, 0, 32'd0);
            cycle();
        end
        chk("br_sat", 32'(br_count), 32'hF);

        // mispred_count saturation
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 32'(i * 8), 0, 0, 0, 32'd0);
            cycle();
            drive(0, 0, 32'd0, 0, 1, 1, 32'(32'h1000 + i));
            cycle();
            drive(0, 0, 32'd0, 0, 0, 0, 32'd0);
            for (int k = 0; k < FLUSH_CYC; k++) cycle();
        end
        chk("mp_sat", 32'(mispred_count), 32'hF);
        chk("mp_sat_br", 32'(br_count), 32'hF);

        // Asynchronous reset in the middle of a flush
        do_reset();
        drive(1, 1, 32'h700, 0, 0, 0, 32'd0);
        cycle();
        drive(1, 0, 32'h704, 0, 1, 0, 32'd0);
        cycle();
        drive(0, 0, 32'd0, 0, 0, 0, 32'd0);
        cycle();
        chk("pre_async_flush", {31'd0, flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 55), $urandom_range(0, 1),
                  {$urandom_range(0, 32'h3FFF), 2'b00}, ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 45), $urandom_range(0, 1), $urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
